// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the run monitor.
// Status encoding, trace entry sizing, saturating increment.
package run_monitor_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_HANG    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  function automatic int trace_width(input int xlen);
    return 2 * xlen + REG_ADDR_W;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/run_monitor_trace_ring.sv
// Ring buffer of the most recent register writes.
// Read index is relative to the newest entry.
module run_monitor_trace_ring #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 69
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    wptr;
  logic [IW-1:0]    rd_ptr;
  logic             wr;

  assign wr = push && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      count <= '0;
    end else if (push) begin
      wptr <= wptr + IW'(1);
      if (count != FULL)
        count <= count + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= data;
  end

  // newest entry sits just behind the write pointer
  assign rd_ptr  = wptr - IW'(1) - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/run_monitor.sv
// Run controller: sequences CPU reset, watches writeback and pc,
// ends the run on pass/fail, hang or timeout.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RESET_CYCLES   = 10,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int STALL_LIMIT    = 16,
  parameter int TRACE_DEPTH    = 8,
  parameter logic [REG_ADDR_W-1:0] TOHOST_REG = 5'd3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              restart,
  input  logic [XLEN-1:0]                   pc,
  input  logic                              wb_en,
  input  logic [REG_ADDR_W-1:0]             wb_addr,
  input  logic [XLEN-1:0]                   wb_data,
  output logic                              cpu_reset,
  output logic [2:0]                        status,
  output logic                              done,
  output logic [XLEN-2:0]                   fail_code,
  output logic [31:0]                       cycle_count,
  output logic [31:0]                       retire_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0]    trace_rd_idx,
  output logic [2*XLEN+REG_ADDR_W-1:0]      trace_rd_data,
  output logic [$clog2(TRACE_DEPTH):0]      trace_count
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam int TW = trace_width(XLEN);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 2);
  localparam logic [31:0]   TIMEOUT_AT = 32'(TIMEOUT_CYCLES);

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [31:0]     cycle_d, retire_d;
  logic [XLEN-2:0] fail_d;
  logic [XLEN-1:0] pc_prev_q, pc_prev_d;
  logic            pc_valid_q, pc_valid_d;
  logic            push, clear;
  logic            same_pc, result;

  assign same_pc = pc_valid_q && (pc == pc_prev_q);
  assign result  = wb_en && (wb_addr == TOHOST_REG)
                && (wb_data != '0);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stall_d    = stall_q;
    cycle_d    = cycle_count;
    retire_d   = retire_count;
    fail_d     = fail_code;
    pc_prev_d  = pc_prev_q;
    pc_valid_d = pc_valid_q;
    push       = 1'b0;
    clear      = 1'b0;
    if (restart) begin
      state_d    = ST_HOLD;
      hold_d     = '0;
      stall_d    = '0;
      cycle_d    = '0;
      retire_d   = '0;
      fail_d     = '0;
      pc_valid_d = 1'b0;
      clear      = 1'b1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          pc_valid_d = 1'b0;
          if (hold_q == HOLD_LAST) begin
            state_d = ST_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        ST_RUN: begin
          cycle_d = sat_inc(cycle_count);
          if (wb_en)
            retire_d = sat_inc(retire_count);
          push       = wb_en && (wb_addr != '0);
          pc_prev_d  = pc;
          pc_valid_d = 1'b1;
          stall_d    = same_pc ? stall_q + SW'(1) : '0;
          // result write outranks hang, hang outranks timeout
          if (result) begin
            if (wb_data == XLEN'(1)) begin
              state_d = ST_PASS;
            end else begin
              state_d = ST_FAIL;
              fail_d  = wb_data[XLEN-1:1];
            end
          end else if (same_pc && stall_q == STALL_LAST) begin
            state_d = ST_HANG;
          end else if (cycle_d == TIMEOUT_AT) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_HOLD;
      hold_q       <= '0;
      stall_q      <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
      fail_code    <= '0;
      pc_prev_q    <= '0;
      pc_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stall_q      <= stall_d;
      cycle_count  <= cycle_d;
      retire_count <= retire_d;
      fail_code    <= fail_d;
      pc_prev_q    <= pc_prev_d;
      pc_valid_q   <= pc_valid_d;
    end
  end

  assign cpu_reset = (state_q == ST_HOLD);
  assign status    = state_q;
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL)
                  || (state_q == ST_HANG) || (state_q == ST_TIMEOUT);

  run_monitor_trace_ring #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TW)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push),
    .data    ({pc, wb_addr, wb_data}),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data),
    .count   (trace_count)
  );

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: scoreboard of expected terminal results,
// plus reset, hold timing, restart and trace readout checks.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        reset, restart, wb_en;
  logic [31:0] pc, wb_data;
  logic [4:0]  wb_addr;
  logic [2:0]  trace_rd_idx;
  logic        cpu_reset, done;
  logic [2:0]  status;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, retire_count;
  logic [68:0] trace_rd_data;
  logic [3:0]  trace_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic [3:0]  tc;
    logic [30:0] fc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  run_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .restart       (restart),
    .pc            (pc),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .cpu_reset     (cpu_reset),
    .status        (status),
    .done          (done),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .retire_count  (retire_count),
    .trace_rd_idx  (trace_rd_idx),
    .trace_rd_data (trace_rd_data),
    .trace_count   (trace_count)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] ent(input logic [31:0] p,
                                      input logic [4:0]  a,
                                      input logic [31:0] d);
    return {p, a, d};
  endfunction

  task automatic rd_trace(input string tag, input int idx,
                          input logic [68:0] exp);
    trace_rd_idx = 3'(idx);
    #1;
    chk(tag, trace_rd_data, exp);
  endtask

  // HOLD lasts 10 edges; writes during HOLD must be ignored
  task automatic wait_hold();
    pc = 32'h40; wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        chk("hold9_status", status, 3'd0);
        chk("hold9_cpurst", cpu_reset, 1'b1);
      end
      if (i == 10) begin
        chk("hold10_status", status, 3'd1);
        chk("hold10_cpurst", cpu_reset, 1'b0);
      end
    end
    wb_en = 1'b0; pc = 32'h0;
    chk("run0_retire", retire_count, 32'd0);
    chk("run0_cycle", cycle_count, 32'd0);
    chk("run0_tcount", trace_count, 4'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd1;
    @(negedge clk);
    restart = 1'b0;
    chk("rst_status", status, 3'd0);
    chk("rst_cpurst", cpu_reset, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_cycle", cycle_count, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_tcount", trace_count, 4'd0);
    chk("rst_fcode", fail_code, 31'd0);
    wait_hold();
  endtask

  task automatic drive(input int kind, input int c,
                       output bit trig, output exp_t e);
    int k;
    pc = 32'(4 * c); wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    trig = 1'b0;
    e = '{st: 3'd0, cyc: 32'd0, ret: 32'd0, tc: 4'd0, fc: 31'd0};
    case (kind)
      0: begin
        if (c == 5) begin
          wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
        end
        if (c == 20) begin
          wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd1;
          trig = 1'b1;
          e = '{st: 3'd2, cyc: 32'd20, ret: 32'd2, tc: 4'd2, fc: 31'd0};
        end
      end
      1: begin
        pc = 32'h80;
        if (c == 16) begin
          wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
          trig = 1'b1;
          e = '{st: 3'd3, cyc: 32'd16, ret: 32'd1, tc: 4'd1, fc: 31'd3};
        end
      end
      2: begin
        pc = 32'h40;
        if (c == 16) begin
          trig = 1'b1;
          e = '{st: 3'd4, cyc: 32'd16, ret: 32'd0, tc: 4'd0, fc: 31'd0};
        end
      end
      default: begin
        k = c / 8;
        if (c % 8 == 0 && k >= 1 && k <= 10) begin
          wb_en   = 1'b1;
          wb_addr = (k == 3) ? 5'd0 : 5'(k + 5);
          wb_data = 32'(32'h100 + k);
        end
        if (c == 90) begin
          wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd0;
        end
        if (c == 100) begin
          trig = 1'b1;
          e = '{st: 3'd5, cyc: 32'd100, ret: 32'd11, tc: 4'd8, fc: 31'd0};
        end
      end
    endcase
  endtask

  task automatic run_case(input int kind, input int maxc);
    exp_t e, x;
    bit   trig;
    bit   seen = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      drive(kind, c, trig, x);
      if (trig) sb.push_back(x);
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    wb_en = 1'b0;
    chk($sformatf("k%0d_done_seen", kind), seen, 1'b1);
    chk($sformatf("k%0d_sb_pending", kind), sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("k%0d_status", kind), status, e.st);
      chk($sformatf("k%0d_cycle", kind), cycle_count, e.cyc);
      chk($sformatf("k%0d_retire", kind), retire_count, e.ret);
      chk($sformatf("k%0d_tcount", kind), trace_count, e.tc);
      chk($sformatf("k%0d_fcode", kind), fail_code, e.fc);
      chk($sformatf("k%0d_cpurst", kind), cpu_reset, 1'b0);
      for (int i = 0; i < 5; i++) begin
        pc = 32'(12 * i); wb_en = 1'b1;
        wb_addr = 5'(i + 3); wb_data = 32'(i + 1);
        @(negedge clk);
      end
      wb_en = 1'b0;
      chk($sformatf("k%0d_frz_status", kind), status, e.st);
      chk($sformatf("k%0d_frz_cycle", kind), cycle_count, e.cyc);
      chk($sformatf("k%0d_frz_retire", kind), retire_count, e.ret);
      chk($sformatf("k%0d_frz_tcount", kind), trace_count, e.tc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; restart = 1'b0; wb_en = 1'b0;
    pc = 32'h0; wb_addr = 5'd0; wb_data = 32'd0;
    trace_rd_idx = 3'd0;
    #2;
    chk("por_status", status, 3'd0);
    chk("por_cpurst", cpu_reset, 1'b1);
    chk("por_done", done, 1'b0);
    chk("por_cycle", cycle_count, 32'd0);
    chk("por_retire", retire_count, 32'd0);
    chk("por_tcount", trace_count, 4'd0);
    chk("por_fcode", fail_code, 31'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_hold();

    run_case(0, 40);
    rd_trace("pass_idx0", 0, ent(32'd80, 5'd3, 32'd1));
    rd_trace("pass_idx1", 1, ent(32'd20, 5'd5, 32'h55));
    rd_trace("pass_idx2_empty", 2, 69'd0);

    do_restart();
    run_case(1, 40);
    rd_trace("fail_idx0", 0, ent(32'h80, 5'd3, 32'd7));

    do_restart();
    run_case(2, 40);

    do_restart();
    run_case(3, 120);
    rd_trace("to_idx0", 0, ent(32'd360, 5'd3, 32'd0));
    rd_trace("to_idx1", 1, ent(32'd320, 5'd15, 32'h10A));
    rd_trace("to_idx7", 7, ent(32'd128, 5'd9, 32'h104));

    do_restart();
    for (int c = 1; c <= 49; c++) begin
      pc = 32'(4 * c);
      wb_en = (c == 10); wb_addr = 5'd7; wb_data = 32'h77;
      @(negedge clk);
    end
    wb_en = 1'b0;
    chk("mid_status", status, 3'd1);
    chk("mid_cycle", cycle_count, 32'd49);
    chk("mid_retire", retire_count, 32'd1);
    chk("mid_tcount", trace_count, 4'd1);
    do_restart();

    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_status", status, 3'd0);
    chk("async_cpurst", cpu_reset, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    wait_hold();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
